// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, frame width, parity types.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int PRESCALE_W     = 6;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/data_sampling.sv
// Three-point majority sampler around the middle of each bit period.
module data_sampling
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] edge_cnt,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  sampled_bit
);

   logic [PRESCALE_W-1:0] mid;
   logic [2:0]            samples;

   assign mid = prescale >> 1;

   // Capture the line one tick before, at, and one tick after mid-bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         samples <= 3'b111;
      end else begin
         if (edge_cnt == mid - 6'd1) samples[0] <= RX_IN;
         if (edge_cnt == mid)        samples[1] <= RX_IN;
         if (edge_cnt == mid + 6'd1) samples[2] <= RX_IN;
      end
   end

   assign sampled_bit = (samples[0] & samples[1]) |
                        (samples[0] & samples[2]) |
                        (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first deserialiser, parity/stop checks.
//
// state  | meaning
// IDLE   | line idle, waiting for RX_IN low; frame settings latched on exit
// START  | start bit; majority 1 at bit end is a glitch, back to IDLE
// DATA   | DATA_WIDTH data bits, LSB first
// PARITY | optional parity bit, compared against the received data
// STOP   | stop bit; result pulses issued as the bit ends
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Error,
   output logic                  Stop_Error
);

   rx_state_e             state, next_state;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] prescale_r;
   logic [2:0]            bit_cnt;
   logic                  par_en_r, par_typ_r, par_err_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  sampled_bit;
   logic                  bit_end, capture, frame_done;

   data_sampling u_sampler (
      .clk         (clk),
      .rst         (rst),
      .RX_IN       (RX_IN),
      .edge_cnt    (edge_cnt),
      .prescale    (prescale_r),
      .sampled_bit (sampled_bit)
   );

   assign bit_end = (edge_cnt == prescale_r - 6'd1);

   // Next-state decode. A start bit already present when STOP ends is taken
   // straight into START so back-to-back frames lose no tick.
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (!RX_IN) begin
               next_state = START;
               capture    = 1'b1;
            end
         end
         START: begin
            if (bit_end) next_state = sampled_bit ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == 3'(DATA_WIDTH - 1))
               next_state = par_en_r ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) next_state = STOP;
         end
         STOP: begin
            if (bit_end) begin
               frame_done = 1'b1;
               if (!RX_IN) begin
                  next_state = START;
                  capture    = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Tick and bit counters plus per-frame settings latched at start detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         prescale_r <= 6'd8;
         par_en_r   <= 1'b0;
         par_typ_r  <= EVEN;
      end else if (capture) begin
         edge_cnt   <= '0;
         bit_cnt    <= '0;
         prescale_r <= prescale;
         par_en_r   <= PAR_EN;
         par_typ_r  <= PAR_TYP;
      end else if (state != IDLE) begin
         edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
         if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Deserialiser, parity check and result pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r    <= '0;
         par_err_r  <= 1'b0;
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
         Par_Error  <= 1'b0;
         Stop_Error <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         Par_Error  <= 1'b0;
         Stop_Error <= 1'b0;
         if (capture) par_err_r <= 1'b0;
         if (state == DATA && bit_end) shift_r[bit_cnt] <= sampled_bit;
         if (state == PARITY && bit_end)
            par_err_r <= sampled_bit != ((^shift_r) ^ par_typ_r);
         if (frame_done) begin
            Par_Error  <= par_err_r;
            Stop_Error <= ~sampled_bit;
            if (sampled_bit && !par_err_r) begin
               P_DATA     <= shift_r;
               Data_Valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// against a frame-level reference model.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       RX_IN;
   logic [5:0] prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Par_Error;
   logic       Stop_Error;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic       dv;
      logic       pe;
      logic       se;
      logic [7:0] data;
      int         cyc;
   } ev_t;

   ev_t        act_q[$];
   ev_t        exp_q[$];
   int         last_cyc[$];
   logic [7:0] model_pdata = 8'h00;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .RX_IN      (RX_IN),
      .prescale   (prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_Error  (Par_Error),
      .Stop_Error (Stop_Error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every cycle in which any result pulse is high.
   always @(negedge clk) begin
      ev_t e;
      if (Data_Valid || Par_Error || Stop_Error) begin
         e.dv   = Data_Valid;
         e.pe   = Par_Error;
         e.se   = Stop_Error;
         e.data = P_DATA;
         e.cyc  = cyc;
         act_q.push_back(e);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame and push the model's expected result.
   // abort_bit >= 0 asserts rst half-way through that line bit instead.
   task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                             input logic pt, input logic bad_par, input logic bad_stop,
                             input logic scramble, input int abort_bit);
      logic bits[$];
      int   start_cyc;
      ev_t  e;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((^d) ^ pt ^ bad_par);
      bits.push_back(~bad_stop);
      prescale  = 6'(p);
      PAR_EN    = pe;
      PAR_TYP   = pt;
      start_cyc = cyc;
      foreach (bits[i]) begin
         RX_IN = bits[i];
         if (i == abort_bit) begin
            tick(p / 2);
            rst   = 1'b1;
            RX_IN = 1'b1;
            tick(3);
            rst         = 1'b0;
            model_pdata = 8'h00;
            return;
         end
         if (i == 1 && scramble) begin
            prescale = (p == 8) ? 6'd32 : 6'd8;
            PAR_EN   = ~pe;
            PAR_TYP  = ~pt;
         end
         tick(p);
      end
      e.pe = pe && bad_par;
      e.se = bad_stop;
      e.dv = !e.pe && !e.se;
      if (e.dv) model_pdata = d;
      e.data = model_pdata;
      e.cyc  = start_cyc + bits.size() * p + 1;
      exp_q.push_back(e);
   endtask

   task automatic check_events(input string name);
      ev_t a, x;
      RX_IN = 1'b1;
      tick(4);
      last_cyc = {};
      n_checks++;
      if (act_q.size() != exp_q.size())
         $display("FAIL %s pulse count: got %0d expected %0d", name, act_q.size(), exp_q.size());
      else n_pass++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front();
         x = exp_q.pop_front();
         last_cyc.push_back(a.cyc);
         n_checks++;
         if ({a.dv, a.pe, a.se} !== {x.dv, x.pe, x.se})
            $display("FAIL %s dv/pe/se: got %b%b%b expected %b%b%b", name,
                     a.dv, a.pe, a.se, x.dv, x.pe, x.se);
         else n_pass++;
         n_checks++;
         if (a.data !== x.data)
            $display("FAIL %s P_DATA at pulse: got %h expected %h", name, a.data, x.data);
         else n_pass++;
         n_checks++;
         if (a.cyc - x.cyc > 1 || x.cyc - a.cyc > 1)
            $display("FAIL %s pulse cycle: got %0d expected %0d", name, a.cyc, x.cyc);
         else n_pass++;
      end
      act_q.delete();
      exp_q.delete();
      n_checks++;
      if (P_DATA !== model_pdata)
         $display("FAIL %s P_DATA held: got %h expected %h", name, P_DATA, model_pdata);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      RX_IN    = 1'b1;
      prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      tick(3);
      rst = 1'b0;
      n_checks++;
      if ({P_DATA, Data_Valid, Par_Error, Stop_Error} !== 11'h000)
         $display("FAIL reset outputs: got %h %b%b%b expected 00 000", P_DATA,
                  Data_Valid, Par_Error, Stop_Error);
      else n_pass++;
      tick(2);
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check_events("basic_a5_p8");
      send_frame(8'h6B, 16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      check_events("odd_parity_ok_p16");
   endtask

   task automatic test_parity_error();
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
      check_events("parity_err_3c");
   endtask

   task automatic test_stop_error();
      send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      check_events("stop_err_81");
      send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      check_events("both_err_c3");
   endtask

   task automatic test_glitch();
      prescale = 6'd16;
      RX_IN    = 1'b0;
      tick(3);
      RX_IN = 1'b1;
      tick(40);
      check_events("glitch");
      send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check_events("after_glitch");
   endtask

   task automatic test_back_to_back();
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check_events("back_to_back");
      n_checks++;
      if (last_cyc.size() != 2)
         $display("FAIL b2b spacing: got %0d pulses expected 2", last_cyc.size());
      else if (last_cyc[1] - last_cyc[0] != 80)
         $display("FAIL b2b spacing: got %0d expected 80", last_cyc[1] - last_cyc[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      send_frame(8'h9E, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
      tick(20);
      n_checks++;
      if ({P_DATA, Data_Valid, Par_Error, Stop_Error} !== 11'h000)
         $display("FAIL mid_reset outputs: got %h %b%b%b expected 00 000", P_DATA,
                  Data_Valid, Par_Error, Stop_Error);
      else n_pass++;
      check_events("mid_reset_quiet");
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      check_events("after_mid_reset_12");
   endtask

   task automatic test_random();
      int   p;
      logic pe, bp, bs;
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         pe = 1'($urandom_range(0, 1));
         bp = pe && ($urandom_range(0, 5) == 0);
         bs = ($urandom_range(0, 5) == 0);
         send_frame(8'($urandom), p, pe, 1'($urandom_range(0, 1)), bp, bs,
                    1'($urandom_range(0, 1)), -1);
         check_events("random");
         tick($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_error();
      test_stop_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
